// File: rtl/div_subshift_pkg.sv
// Shared definitions for the restoring subtract-and-shift divider: FSM encoding,
// counter sizing and the all-ones quotient helper.
package div_subshift_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic [63:0] ALL_ONES_64 = '1;

  // Iteration counter width; never below one bit, even for DATA_W == 2.
  function automatic int cnt_width(input int data_w);
    return (data_w <= 2) ? 1 : $clog2(data_w);
  endfunction

  // Quotient produced by a divide-by-zero, truncated to the datapath width.
  function automatic logic [63:0] all_ones(input int data_w);
    return ALL_ONES_64 >> (64 - data_w);
  endfunction

endpackage

// File: rtl/div_subshift_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, then subtract the divisor if that does not borrow.
module div_subshift_step
  import div_subshift_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic              bit_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              quo_bit
);

  logic [DATA_W:0]   shifted;
  logic [DATA_W+1:0] diff;
  logic              borrow;

  // Extra top bit of diff captures the borrow out of the (DATA_W+1)-bit trial.
  assign shifted = {rem_in, bit_in};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};
  assign borrow  = diff[DATA_W+1];

  assign quo_bit = ~borrow;
  assign rem_out = borrow ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];

endmodule

// File: rtl/div_subshift_unit.sv
// Sequential unsigned divider, one quotient bit per clock, start/done handshake.
// Optional macro DIV_SUBSHIFT_DBZ_EN adds a registered divide-by-zero flag (dbz).
module div_subshift_unit
  import div_subshift_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
`ifdef DIV_SUBSHIFT_DBZ_EN
  output logic              dbz,
`endif
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = cnt_width(DATA_W);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] div_r;
  logic [DATA_W-1:0] rem_acc;
  logic [DATA_W-1:0] quo_acc;
  logic [DATA_W-1:0] step_rem;
  logic              step_q;
  logic              accept;

  assign accept = start && (state == ST_IDLE || state == ST_DONE);

  div_subshift_step #(.DATA_W(DATA_W)) u_step (
    .rem_in  (rem_acc),
    .bit_in  (quo_acc[DATA_W-1]),
    .divisor (div_r),
    .rem_out (step_rem),
    .quo_bit (step_q)
  );

  // Divisor is only consumed while BUSY, after a start has loaded it.
  always_ff @(posedge clk) begin
    if (accept) div_r <= divisor;
  end

  // Control and shift register; the quotient shifts in from the LSB as the
  // dividend shifts out of the MSB into the step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rem_acc <= '0;
      quo_acc <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_BUSY;
            cnt     <= CNT_W'(DATA_W - 1);
            rem_acc <= '0;
            quo_acc <= dividend;
          end
        end
        ST_BUSY: begin
          rem_acc <= step_rem;
          quo_acc <= {quo_acc[DATA_W-2:0], step_q};
          if (cnt == '0) state <= ST_DONE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DIV_SUBSHIFT_DBZ_EN
  always_ff @(posedge clk) begin
    if (rst)         dbz <= 1'b0;
    else if (accept) dbz <= (divisor == '0);
  end
`endif

  assign done      = (state == ST_DONE);
  assign quotient  = quo_acc;
  assign remainder = rem_acc;

endmodule

// File: tb/tb_div_subshift_unit.sv
// Directed and random checks of div_subshift_unit at DATA_W = 8.
module tb_div_subshift_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         done;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
`ifdef DIV_SUBSHIFT_DBZ_EN
  logic         dbz;
`endif

  int checks   = 0;
  int failures = 0;

  div_subshift_unit #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .done      (done),
`ifdef DIV_SUBSHIFT_DBZ_EN
    .dbz       (dbz),
`endif
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // mode 0: plain; 1: re-pulse start mid-BUSY with other operands;
  // 2: change operands right after the start edge.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input int mode,
                         input logic [W-1:0] exp_q, input logic [W-1:0] exp_r);
    int cyc;
    bit got;
    @(posedge clk); #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, ".done_low"}, done, 1'b0);
    cyc = 0;
    got = 0;
    while (!got && cyc < 20) begin
      start = (cyc + 1 < hold) || (mode == 1 && cyc == 3);
      if (mode == 1 && cyc == 3) begin
        dividend = 8'd1;
        divisor  = 8'd1;
      end
      if (mode == 2 && cyc == 0) begin
        dividend = ~a;
        divisor  = b + 8'd3;
      end
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1;
    end
    start = 1'b0;
    check_eq({tag, ".latency"}, cyc, 8);
    check_eq({tag, ".q"}, quotient, exp_q);
    check_eq({tag, ".r"}, remainder, exp_r);
`ifdef DIV_SUBSHIFT_DBZ_EN
    check_eq({tag, ".dbz"}, dbz, (b == 8'd0));
`endif
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.done", done, 1'b0);
    check_eq("reset.q", quotient, 8'd0);
    check_eq("reset.r", remainder, 8'd0);
`ifdef DIV_SUBSHIFT_DBZ_EN
    check_eq("reset.dbz", dbz, 1'b0);
`endif
    rst = 1'b0;
    dividend = 8'd99;
    divisor  = 8'd5;
    repeat (5) @(posedge clk);
    #1;
    check_eq("idle.done", done, 1'b0);
    check_eq("idle.q", quotient, 8'd0);

    run_div("basic", 8'd200, 8'd7, 1, 0, 8'd28, 8'd4);
    repeat (6) @(posedge clk);
    #1;
    check_eq("hold.done", done, 1'b1);
    check_eq("hold.q", quotient, 8'd28);
    check_eq("hold.r", remainder, 8'd4);

    run_div("d255_1", 8'd255, 8'd1, 1, 0, 8'd255, 8'd0);
    run_div("d5_9", 8'd5, 8'd9, 1, 0, 8'd0, 8'd5);
    run_div("d0_3", 8'd0, 8'd3, 1, 0, 8'd0, 8'd0);
    run_div("d255_255", 8'd255, 8'd255, 1, 0, 8'd1, 8'd0);
    run_div("dbz77", 8'd77, 8'd0, 1, 0, 8'd255, 8'd77);
    run_div("d77_7", 8'd77, 8'd7, 1, 0, 8'd11, 8'd0);
    run_div("repulse", 8'd100, 8'd9, 1, 1, 8'd11, 8'd1);
    run_div("opchange", 8'd150, 8'd12, 1, 2, 8'd12, 8'd6);
    run_div("held", 8'd97, 8'd10, 3, 0, 8'd9, 8'd7);

    // Abort a division in flight with reset.
    @(posedge clk); #1;
    dividend = 8'd250;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort.done", done, 1'b0);
    check_eq("abort.q", quotient, 8'd0);
    check_eq("abort.r", remainder, 8'd0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("abort.stays_idle", done, 1'b0);
    run_div("after_abort", 8'd250, 8'd3, 1, 0, 8'd83, 8'd1);

    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a, b, eq, er;
      a = W'($urandom_range(0, 255));
      b = (i % 50 == 0) ? 8'd0 : W'($urandom_range(0, 255));
      if (b == 8'd0) begin
        eq = 8'd255;
        er = a;
      end else begin
        eq = a / b;
        er = a % b;
      end
      run_div($sformatf("rnd%0d", i), a, b, 1, 0, eq, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_subshift_unit.md
Name: div_subshift_unit

Overview:
- Unsigned integer divider using the sequential subtract-and-shift (restoring) algorithm, one quotient bit per clock.
- Start/done handshake; operands sampled on start; quotient and remainder are registered and held until the next start.
- Used as a small-area arithmetic helper wherever multi-cycle latency is acceptable.

Parameters:
- DATA_W, 8, width of dividend, divisor, quotient and remainder; legal range 2..64.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse requesting a division
- done  output  1  high when quotient/remainder hold a valid result
- dividend  input  DATA_W  unsigned numerator, sampled when start accepted
- divisor  input  DATA_W  unsigned denominator, sampled when start accepted
- quotient  output  DATA_W  unsigned quotient
- remainder  output  DATA_W  unsigned remainder

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). rst has priority over start.
- Reset values: done=0, quotient=0, remainder=0, state IDLE, counter 0.
- States:
  - IDLE: done=0; start -> BUSY.
  - BUSY: counter runs DATA_W-1 down to 0; counter==0 completes -> DONE.
  - DONE: done=1; start -> BUSY.
- Accepting start (edge where start=1 in IDLE or DONE):
  - latch divisor;
  - load the shift register {rem_acc[DATA_W-1:0], quo_acc[DATA_W-1:0]} = {0, dividend};
  - counter = DATA_W-1; done drops to 0 on that same edge.
- Each BUSY cycle:
  - trial = {rem_acc, quo_acc[DATA_W-1]} (DATA_W+1 bits) minus {0, divisor};
  - no borrow: rem_acc = trial[DATA_W-1:0], shift 1 into quo_acc LSB;
  - borrow: rem_acc = shifted value, shift 0 into quo_acc LSB.
- Latency: start sampled at edge N, DATA_W iteration edges N+1..N+DATA_W, done=1 after edge N+DATA_W; with DATA_W=8 done is high 8 cycles after start is sampled.
- done remains high and outputs remain stable indefinitely until the next accepted start.
- quotient/remainder are valid only while done=1; during BUSY they are undefined to the user.
- start while BUSY: ignored; the computation in flight completes unaffected.
- Start held high for multiple cycles: accepted once, then ignored while BUSY. If still high on the cycle done is asserted, a new division starts on the next edge.
- dividend/divisor may change after the start edge without effect.
- Division by zero: no special path. The algorithm naturally yields quotient = all ones (2^DATA_W-1) and remainder = dividend, with normal latency; this result is required.
- Result identity whenever divisor != 0: dividend == quotient*divisor + remainder and remainder < divisor.
- rst asserted mid-BUSY: returns to IDLE with reset values on that edge; the computation is aborted.

Optional Feature:
- Macro DIV_SUBSHIFT_DBZ_EN.
- Defined: adds output port dbz (1 bit, reset 0), registered at start acceptance as (divisor==0), valid while done=1; quotient/remainder and timing are unchanged.
- Undefined: no dbz port, no related logic.

Decomposition:
- Shared package div_subshift_pkg:
  - state encoding (IDLE, BUSY, DONE);
  - counter width constant CNT_W = $clog2(DATA_W) (minimum 1);
  - localparam helper for the all-ones quotient.
- One natural sub-module, div_subshift_step: purely combinational single iteration; inputs rem_acc, next dividend bit and divisor; outputs new rem_acc and quotient bit. The top instantiates it once and sequences it with the counter.

Test Plan:
- Reset then idle: rst pulse -> done=0, quotient=0, remainder=0; no activity without start.
- Basic: dividend=200, divisor=7, 1-cycle start -> done low on the start edge, high exactly 8 cycles later; quotient=28, remainder=4; outputs held while start stays low.
- Edges:
  - 255/1 -> q=255, r=0;
  - 5/9 -> q=0, r=5;
  - 0/3 -> q=0, r=0;
  - 255/255 -> q=1, r=0.
- Divide by zero: 77/0 -> q=255, r=77 after normal latency; with DIV_SUBSHIFT_DBZ_EN, dbz=1 (and dbz=0 on the following 77/7 -> q=11, r=0).
- Protocol:
  - start re-pulsed mid-BUSY -> ignored, original result correct;
  - operands changed after the start edge -> no effect;
  - rst mid-BUSY -> done=0, outputs 0, next start works.
- Random regression: 1000 random 8-bit operand pairs, back-to-back start after each done -> every result matches / and %, using the division-by-zero rule for divisor=0.
